// File: rtl/stash_input_ctrl.sv
// Button/switch front end for the sample stash: synchronizes raw inputs, debounces the two
// buttons and produces one-cycle store/advance strobes plus the captured switch value.
module stash_input_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_store,
    input  logic             btn_next,
    output logic [WIDTH-1:0] sample_in,
    output logic             sample_in_valid,
    output logic             next_sample
);

    localparam int unsigned    CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    // Index 0 is the store button, index 1 the next button.
    logic [WIDTH-1:0] sw_meta_q;
    logic [WIDTH-1:0] s_sw;
    logic [1:0]       btn_meta_q;
    logic [1:0]       s_btn;

    logic [1:0]    state_q [2];
    logic [1:0]    state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [1:0]    pulse_d;

    logic pending_q;
    logic store_pulse;
    logic next_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q  <= '0;
            s_sw       <= '0;
            btn_meta_q <= '0;
            s_btn      <= '0;
        end else begin
            sw_meta_q  <= sw;
            s_sw       <= sw_meta_q;
            btn_meta_q <= {btn_next, btn_store};
            s_btn      <= btn_meta_q;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pulse_d[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (s_btn[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s_btn[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = PRESSED;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!s_btn[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = CW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (s_btn[i]) begin
                        state_d[i] = PRESSED;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // A next request colliding with a store is deferred one cycle via pending_q.
    assign store_pulse = pulse_d[0];
    assign next_req    = pulse_d[1] | pending_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_in       <= '0;
            sample_in_valid <= 1'b0;
            next_sample     <= 1'b0;
            pending_q       <= 1'b0;
        end else begin
            sample_in_valid <= store_pulse;
            next_sample     <= next_req & ~store_pulse;
            pending_q       <= next_req & store_pulse;
            if (store_pulse) begin
                sample_in <= s_sw;
            end
        end
    end

endmodule

// File: tb/tb_stash_input_ctrl.sv
// Scoreboard bench for stash_input_ctrl: stimulus queues expected strobes, a negedge monitor
// pops and checks them as the DUT raises sample_in_valid / next_sample.
module tb_stash_input_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned DB = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw;
    logic         btn_store;
    logic         btn_next;
    logic [W-1:0] sample_in;
    logic         sample_in_valid;
    logic         next_sample;

    stash_input_ctrl #(.WIDTH(W), .DEBOUNCE(DB)) dut (
        .clk             (clk),
        .reset           (reset),
        .sw              (sw),
        .btn_store       (btn_store),
        .btn_next        (btn_next),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .next_sample     (next_sample)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } exp_t;

    exp_t store_q[$];
    int   next_q[$];
    int   tests = 0;
    int   fails = 0;
    int   c0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_store(input int at, input logic [W-1:0] d);
        exp_t e;
        e.cyc  = at;
        e.data = d;
        store_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        int   nc;
        if (!reset) begin
            if (sample_in_valid || next_sample)
                check("no_overlap", {31'd0, sample_in_valid & next_sample}, 32'd0);
            if (sample_in_valid) begin
                if (store_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_store: got sample_in=%0h at cycle %0d, expected none",
                             sample_in, cyc);
                end else begin
                    e = store_q.pop_front();
                    check("store_cycle", cyc, e.cyc);
                    check("store_data", {24'd0, sample_in}, {24'd0, e.data});
                end
            end
            if (next_sample) begin
                if (next_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_next: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    nc = next_q.pop_front();
                    check("next_cycle", cyc, nc);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        sw        = '0;
        btn_store = 1'b0;
        btn_next  = 1'b0;
        tick(3);
        check("rst_sample_in", {24'd0, sample_in}, 32'd0);
        check("rst_valid", {31'd0, sample_in_valid}, 32'd0);
        check("rst_next", {31'd0, next_sample}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Clean press, held long; sw changes after capture must not leak through.
        sw        = 8'h2A;
        btn_store = 1'b1;
        expect_store(cyc + 6, 8'h2A);
        tick(6);
        sw = 8'h55;
        tick(22);
        btn_store = 1'b0;
        tick(10);
        check("hold_sample", {24'd0, sample_in}, 32'h2A);

        // Bouncy next press rejected, then a clean hold
        btn_next = 1'b1; tick(2);
        btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(2);
        btn_next = 1'b0; tick(8);
        btn_next = 1'b1;
        next_q.push_back(cyc + 6);
        tick(10);
        btn_next = 1'b0;
        tick(10);

        // Release bounce gives no second store, then a new clean press
        sw        = 8'h11;
        btn_store = 1'b1;
        expect_store(cyc + 6, 8'h11);
        tick(10);
        btn_store = 1'b0; tick(1);
        btn_store = 1'b1; tick(1);
        btn_store = 1'b0; tick(10);
        sw        = 8'h22;
        btn_store = 1'b1;
        expect_store(cyc + 6, 8'h22);
        tick(8);
        btn_store = 1'b0;
        tick(10);

        // Simultaneous store and next
        sw        = 8'h33;
        btn_store = 1'b1;
        btn_next  = 1'b1;
        expect_store(cyc + 6, 8'h33);
        next_q.push_back(cyc + 7);
        tick(8);
        btn_store = 1'b0;
        btn_next  = 1'b0;
        tick(10);

        // Stream of seven samples
        for (int i = 0; i < 7; i++) begin
            sw        = W'(i);
            btn_store = 1'b1;
            expect_store(cyc + 6, W'(i));
            tick(7);
            btn_store = 1'b0;
            tick(8);
        end
        check("stream_last", {24'd0, sample_in}, 32'd6);

        // Asynchronous reset mid-press, button kept held
        sw        = 8'h77;
        btn_store = 1'b1;
        c0        = cyc;
        tick(4);
        #1 reset = 1'b1;
        #1;
        check("async_rst_sample_in", {24'd0, sample_in}, 32'd0);
        check("async_rst_valid", {31'd0, sample_in_valid}, 32'd0);
        check("async_rst_next", {31'd0, next_sample}, 32'd0);
        #1 reset = 1'b0;
        expect_store(c0 + 10, 8'h77);
        tick(12);
        btn_store = 1'b0;
        tick(20);

        check("store_queue_drained", store_q.size(), 32'd0);
        check("next_queue_drained", next_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stash_input_ctrl.md
STASH_INPUT_CTRL -- requirements
Module: stash_input_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits.
REQ-002 Parameter DEBOUNCE, default 1000000, consecutive stable cycles required to accept a button level change; legal range >= 1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sw  input  WIDTH  raw asynchronous switch value to be stored.
REQ-006 btn_store  input  1  raw asynchronous, bouncy "store sample" button; high = pressed.
REQ-007 btn_next  input  1  raw asynchronous, bouncy "show next sample" button; high = pressed.
REQ-008 sample_in  output  WIDTH  registered captured switch value, feeds the downstream stash.
REQ-009 sample_in_valid  output  1  registered one-cycle store strobe.
REQ-010 next_sample  output  1  registered one-cycle advance strobe.

Function
REQ-011 sw, btn_store and btn_next SHALL each pass through a 2-flop synchronizer before any other use; s_store, s_next and s_sw denote the synchronized values.
REQ-012 Each button SHALL have its own FSM with a counter cnt: states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: s=1 -> PRESS_WAIT with cnt=1; otherwise stay in IDLE.
REQ-014 PRESS_WAIT: s=0 -> IDLE with cnt=0 (bounce rejected); s=1 and cnt<DEBOUNCE -> cnt+1; s=1 and cnt==DEBOUNCE -> PRESSED and raise the button's pulse for exactly one cycle.
REQ-015 PRESSED: s=0 -> RELEASE_WAIT with cnt=1; otherwise stay, with no further pulses however long the button is held.
REQ-016 RELEASE_WAIT: s=1 -> PRESSED, no pulse; s=0 and cnt<DEBOUNCE -> cnt+1; s=0 and cnt==DEBOUNCE -> IDLE.
REQ-017 Latency: for a clean press first sampled at rising edge 0, the pulse SHALL be registered high at edge DEBOUNCE+2 and low again at edge DEBOUNCE+3.
REQ-018 cnt SHALL be ceil(log2(DEBOUNCE+1)) bits wide and SHALL never wrap.
REQ-019 At the edge where the store pulse is asserted, sample_in SHALL load s_sw; sample_in SHALL hold that value until the next store pulse.
REQ-020 sample_in_valid SHALL equal the store pulse.
REQ-021 next_sample SHALL equal the next pulse, except as given in REQ-022.
REQ-022 If the store and next pulses occur in the same cycle, sample_in_valid SHALL fire in that cycle, a pending flag SHALL be set, and next_sample SHALL fire in the following cycle instead.
REQ-023 sample_in_valid and next_sample SHALL never be high in the same cycle.
REQ-024 Changes on sw while no store pulse occurs SHALL have no effect on any output.

Reset
REQ-025 While reset is high, the synchronizers, counters and pending flag SHALL be 0, both FSMs SHALL be in IDLE, sample_in SHALL be 0, and sample_in_valid and next_sample SHALL be 0. These values SHALL apply immediately, without waiting for a clock edge.
REQ-026 Reset asserted mid-press SHALL drop any pending or in-flight pulse; after release, a button still held SHALL be treated as a new press that restarts from IDLE.

Verification (DEBOUNCE=3, WIDTH=8, 10 ns clock)
REQ-027 Clean press: sw=8'h2A, btn_store held high from edge 0 -> sample_in_valid high for exactly one cycle after edge 5, sample_in=8'h2A from edge 5; no further pulse while held for 20 cycles.
REQ-028 Bounce: btn_next high 2 cycles, low 1, high 2, low -> no next_sample pulse; then held high 10 cycles -> exactly one next_sample pulse.
REQ-029 Release bounce: after an accepted press, btn_store low 1 cycle, high 1 cycle, then low -> no second sample_in_valid; a subsequent clean press gives one new pulse.
REQ-030 Simultaneous: btn_store and btn_next rise at the same edge -> sample_in_valid at edge 5, next_sample at edge 6, never both high together.
REQ-031 Reset mid-press: reset pulsed asynchronously at edge 3 of a store press -> outputs 0 immediately, no pulse at edge 5; with the button still held, the pulse appears DEBOUNCE+2 edges after reset deasserts.
REQ-032 Stream: store sw=0..6 via seven clean presses -> exactly seven sample_in_valid pulses, carrying sample_in 0 through 6 in order.
